// File: rtl/cacheline_burst_adaptor.sv
// cacheline_burst_adaptor: splits 256-bit line fills/writebacks into 4-beat 64-bit memory bursts
module cacheline_burst_adaptor #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addr,
  input  logic              read,
  input  logic              write,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata,
  output logic              resp,
  output logic [31:0]       bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_resp
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d, cnt_n;
  logic [LINE_W-1:0] line_q, line_d, rdata_q, rdata_d;
  logic resp_q, resp_d, bmem_read_q, bmem_read_d, bmem_write_q, bmem_write_d;
  logic [31:0] bmem_addr_q, bmem_addr_d;
  logic [BEAT_W-1:0] bmem_wdata_q, bmem_wdata_d;
  assign cnt_n = cnt_q + 2'd1;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    line_d = line_q;
    rdata_d = rdata_q;
    resp_d = 1'b0;
    bmem_read_d = bmem_read_q;
    bmem_write_d = bmem_write_q;
    bmem_addr_d = bmem_addr_q;
    bmem_wdata_d = bmem_wdata_q;
    case (state_q)
      IDLE: begin
        // a write wins over a simultaneous read
        if (write) begin
          line_d = wdata;
          bmem_addr_d = addr & 32'hFFFF_FFE0;
          bmem_write_d = 1'b1;
          bmem_wdata_d = wdata[BEAT_W-1:0];
          state_d = WRITE;
        end else if (read) begin
          bmem_addr_d = addr & 32'hFFFF_FFE0;
          bmem_read_d = 1'b1;
          state_d = READ;
        end
      end
      READ: if (bmem_resp) begin
        line_d[BEAT_W*cnt_q +: BEAT_W] = bmem_rdata;
        cnt_d = cnt_n;
        if (cnt_q == 2'd3) begin
          bmem_read_d = 1'b0;
          rdata_d = line_d;
          resp_d = 1'b1;
          state_d = DONE;
        end
      end
      WRITE: if (bmem_resp) begin
        cnt_d = cnt_n;
        bmem_wdata_d = line_q[BEAT_W*cnt_n +: BEAT_W];
        if (cnt_q == 2'd3) begin
          bmem_write_d = 1'b0;
          resp_d = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      line_q <= '0;
      rdata_q <= '0;
      resp_q <= 1'b0;
      bmem_read_q <= 1'b0;
      bmem_write_q <= 1'b0;
      bmem_addr_q <= '0;
      bmem_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      line_q <= line_d;
      rdata_q <= rdata_d;
      resp_q <= resp_d;
      bmem_read_q <= bmem_read_d;
      bmem_write_q <= bmem_write_d;
      bmem_addr_q <= bmem_addr_d;
      bmem_wdata_q <= bmem_wdata_d;
    end
  end
  assign rdata = rdata_q;
  assign resp = resp_q;
  assign bmem_addr = bmem_addr_q;
  assign bmem_read = bmem_read_q;
  assign bmem_write = bmem_write_q;
  assign bmem_wdata = bmem_wdata_q;
endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// tb_cacheline_burst_adaptor: directed fills/writebacks with a line and beat scoreboard
module tb_cacheline_burst_adaptor;
  logic clk = 1'b0, rst = 1'b1, read = 1'b0, write = 1'b0, bmem_resp = 1'b0;
  logic [31:0] addr = '0;
  logic [255:0] wdata = '0;
  logic [63:0] bmem_rdata = '0;
  logic [255:0] rdata;
  logic resp, bmem_read, bmem_write;
  logic [31:0] bmem_addr;
  logic [63:0] bmem_wdata;
  int checks = 0, errors = 0;
  logic [255:0] line_q[$];
  logic [63:0] beat_q[$];

  cacheline_burst_adaptor dut (
    .clk(clk), .rst(rst), .addr(addr), .read(read), .write(write), .wdata(wdata),
    .rdata(rdata), .resp(resp), .bmem_addr(bmem_addr), .bmem_read(bmem_read),
    .bmem_write(bmem_write), .bmem_wdata(bmem_wdata), .bmem_rdata(bmem_rdata),
    .bmem_resp(bmem_resp)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_resp"}, 256'(resp), 256'(0));
    chk({tag, "_bmem_read"}, 256'(bmem_read), 256'(0));
    chk({tag, "_bmem_write"}, 256'(bmem_write), 256'(0));
    chk({tag, "_bmem_addr"}, 256'(bmem_addr), 256'(0));
    chk({tag, "_bmem_wdata"}, 256'(bmem_wdata), 256'(0));
    chk({tag, "_rdata"}, rdata, 256'(0));
  endtask

  task automatic wait_resp(inout int lat);
    int w = 0;
    while (resp !== 1'b1 && w < 4) begin
      step();
      w++;
      lat++;
    end
    chk("resp_seen", 256'(resp), 256'(1));
  endtask

  task automatic fill(input logic [31:0] a, input logic [255:0] line, input int gap, output int lat);
    line_q.push_back(line);
    addr = a;
    read = 1'b1;
    bmem_resp = 1'b0;
    lat = 0;
    step();
    lat++;
    chk("fill_bmem_read", 256'(bmem_read), 256'(1));
    chk("fill_bmem_addr", 256'(bmem_addr), 256'({a[31:5], 5'b0}));
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) begin
        bmem_resp = 1'b0;
        step();
        lat++;
      end
      bmem_resp = 1'b1;
      bmem_rdata = line[64*b +: 64];
      step();
      lat++;
    end
    bmem_resp = 1'b0;
    read = 1'b0;
    wait_resp(lat);
    chk("fill_rdata", rdata, line_q.pop_front());
    chk("fill_bmem_read_down", 256'(bmem_read), 256'(0));
  endtask

  task automatic wb(input logic [31:0] a, input logic [255:0] line, input int gap,
                    input logic rd, input logic [255:0] keep);
    int lat = 0;
    for (int b = 0; b < 4; b++) beat_q.push_back(line[64*b +: 64]);
    addr = a;
    write = 1'b1;
    read = rd;
    wdata = line;
    bmem_resp = 1'b0;
    step();
    chk("wb_bmem_write", 256'(bmem_write), 256'(1));
    chk("wb_no_bmem_read", 256'(bmem_read), 256'(0));
    chk("wb_bmem_addr", 256'(bmem_addr), 256'({a[31:5], 5'b0}));
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) begin
        bmem_resp = 1'b0;
        step();
        chk("wb_hold", 256'(bmem_wdata), 256'(beat_q[0]));
      end
      chk("wb_beat", 256'(bmem_wdata), 256'(beat_q.pop_front()));
      bmem_resp = 1'b1;
      step();
    end
    bmem_resp = 1'b0;
    write = 1'b0;
    read = 1'b0;
    wait_resp(lat);
    chk("wb_latency_after_ack", 256'(lat), 256'(0));
    chk("wb_bmem_write_down", 256'(bmem_write), 256'(0));
    chk("wb_rdata_kept", rdata, keep);
  endtask

  task automatic done_step();
    step();
    chk("resp_single_pulse", 256'(resp), 256'(0));
  endtask

  initial begin
    int lat;
    logic [255:0] fl, rl, dl;
    fl = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    dl = {64'hD3D3_0003_D3D3_0003, 64'hD2D2_0002_D2D2_0002,
          64'hD1D1_0001_D1D1_0001, 64'hD0D0_0000_D0D0_0000};
    for (int i = 0; i < 8; i++) rl[32*i +: 32] = $urandom;
    // reset held with a pending read
    read = 1'b1;
    addr = 32'h0000_0040;
    step();
    chk_reset("rst1");
    step();
    chk_reset("rst2");
    rst = 1'b0;
    step();
    chk("bmem_read_after_rst", 256'(bmem_read), 256'(1));
    // two beats then reset mid-burst
    bmem_resp = 1'b1;
    bmem_rdata = 64'hDEAD_BEEF_0000_0000;
    step();
    bmem_rdata = 64'hDEAD_BEEF_0000_0001;
    step();
    rst = 1'b1;
    bmem_resp = 1'b0;
    step();
    chk_reset("mid_rst");
    rst = 1'b0;
    read = 1'b0;
    step();
    chk("mid_rst_no_resp", 256'(resp), 256'(0));
    chk("mid_rst_idle", 256'(bmem_read), 256'(0));
    fill(32'h0000_1234, fl, 0, lat);
    chk("fill_latency", 256'(lat), 256'(5));
    done_step();
    wb(32'h8000_0047, dl, 2, 1'b0, fl);
    done_step();
    wb(32'h0000_2000, ~dl, 0, 1'b1, fl);
    done_step();
    fill(32'hABCD_EF9F, rl, 1, lat);
    chk("fill_stall_latency", 256'(lat), 256'(9));
    write = 1'b1;
    wdata = dl ^ rl;
    addr = 32'h0000_3000;
    step();
    chk("b2b_done_ignored", 256'(bmem_write), 256'(0));
    wb(32'h0000_3000, dl ^ rl, 1, 1'b0, rl);
    done_step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
